io_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the SoC IO bus, selected when mem_address[22] = 1 (IO base 0x00400000).
- Consumes CPU byte writes, buffers them in a small FIFO and serialises them 8N1 on a TX pin.
- Returns a registered status word on the IO read-data path, with the same 1-cycle read latency as RAM.
- Optionally raises an interrupt toward the CPU interrupt_request input.

---
 rtl/io_uart_tx.sv | 253 +++++++++++++++++++++++++
 tb/tb_io_uart_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and a registered STATUS read path.
// Optional interrupt output is built only when UART_TX_IRQ_EN is defined.
module io_uart_tx #(
    parameter int CLK_FREQ   = 10000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_sel,
    input  logic [7:0]  io_word_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] io_rdata,
    output logic        tx,
    output logic        irq
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int AW  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW  = AW + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("io_uart_tx: CLK_FREQ/BAUD must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 64) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("io_uart_tx: FIFO_DEPTH must be a power of 2 in 2..64");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          tx_q, tx_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];

    logic sel_tx_s, sel_st_s, push_s, push_ok_s, pop_s, ovf_clr_s;
    logic full_s, empty_s, baud_end_s, irq_en_s, unused_s;
    logic [7:0]  head_s;
    logic [31:0] status_s;

    assign sel_tx_s   = io_sel & (io_word_address == 8'h01);
    assign sel_st_s   = io_sel & (io_word_address == 8'h02);
    assign push_s     = sel_tx_s & mem_wmask[0];
    assign ovf_clr_s  = sel_st_s & mem_wmask[0] & mem_wdata[3];
    assign full_s     = (count_q == DEPTH_N);
    assign empty_s    = (count_q == {NW{1'b0}});
    assign baud_end_s = (baud_q == BAUD_LAST);
    assign head_s     = mem_q[rd_ptr_q];
    // A full FIFO still takes a byte when the shifter pops in the same cycle.
    assign push_ok_s  = push_s & (~full_s | pop_s);

    // FIFO storage, pointers, occupancy and sticky overflow
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = mem_wdata[7:0];
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
        if (ovf_clr_s) begin
            overflow_d = 1'b0;
        end else if (push_s & full_s & ~pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Serialiser FSM: next state, baud counter, shift register and pop request
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = head_s;
                    baud_d  = {CW{1'b0}};
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_end_s) begin
                    baud_d  = {CW{1'b0}};
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    baud_d  = {CW{1'b0}};
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_STOP: begin
                if (baud_end_s) begin
                    baud_d = {CW{1'b0}};
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = head_s;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = {CW{1'b0}};
            end
        endcase
        // tx is registered, so it is derived from where the FSM is heading.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // STATUS word and the registered read-data mux
    always_comb begin
        status_s       = 32'h0000_0000;
        status_s[0]    = full_s;
        status_s[1]    = empty_s;
        status_s[2]    = (state_q != S_IDLE);
        status_s[3]    = overflow_q;
        status_s[8]    = irq_en_s;
        status_s[15:9] = 7'(count_q);
        if (sel_st_s & mem_rstrb) begin
            rdata_d = status_s;
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            baud_q     <= {CW{1'b0}};
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {NW{1'b0}};
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
            rdata_q    <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
            rdata_q    <= rdata_d;
        end
    end

    // FIFO payload needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign tx       = tx_q;
    assign io_rdata = rdata_q;

`ifdef UART_TX_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q, irq_d;

    // Interrupt enable register and level interrupt "idle and drained"
    always_comb begin
        if (sel_st_s & mem_wmask[1]) begin
            irq_en_d = mem_wdata[8];
        end else begin
            irq_en_d = irq_en_q;
        end
        irq_d = irq_en_q & empty_s & (state_q == S_IDLE);
    end

    // Interrupt registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en_s = irq_en_q;
    assign irq      = irq_q;
    assign unused_s = ^{mem_wdata[31:9], mem_wmask[3:2]};
`else
    assign irq_en_s = 1'b0;
    assign irq      = 1'b0;
    assign unused_s = ^{mem_wdata[31:8], mem_wmask[3:1]};
`endif

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: directed steps with random payloads, a line decoder
// and cycle-exact frame expectations computed from the 8N1 framing rules.
module tb_io_uart_tx;
    localparam int CLK_FREQ = 10000000;
    localparam int BAUD     = 1000000;
    localparam int DEPTH    = 8;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * DIV;
`ifdef UART_TX_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        io_sel = 1'b0;
    logic [7:0]  io_word_address = 8'h00;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_wmask = 4'h0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] io_rdata;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    io_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .io_sel(io_sel), .io_word_address(io_word_address),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb),
        .io_rdata(io_rdata), .tx(tx), .irq(irq)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level k cycles into a frame carrying byte b.
    function automatic logic exp_tx(input logic [7:0] b, input int k);
        int slot;
        slot = k / DIV;
        if (slot == 0) return 1'b0;
        else if (slot <= 8) return b[slot-1];
        else return 1'b1;
    endfunction

    function automatic logic [31:0] st(input int cnt, input bit busy, input bit ovf, input bit ien);
        logic [31:0] v;
        v = 32'h0;
        v[15:9] = cnt[6:0];
        v[8] = ien;
        v[3] = ovf;
        v[2] = busy;
        v[1] = (cnt == 0);
        v[0] = (cnt == DEPTH);
        return v;
    endfunction

    task automatic idle_bus();
        io_sel = 1'b0; io_word_address = 8'h00; mem_wdata = 32'h0; mem_wmask = 4'h0; mem_rstrb = 1'b0;
    endtask

    task automatic wr(input logic sel, input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        io_sel = sel; io_word_address = a; mem_wdata = d; mem_wmask = m;
        @(negedge clk);
        idle_bus();
    endtask

    task automatic wr_byte(input logic [7:0] b);
        logic [31:0] r;
        r = $urandom();
        r[7:0] = b;
        wr(1'b1, 8'h01, r, 4'b0001);
    endtask

    task automatic rd_status(output logic [31:0] v);
        io_sel = 1'b1; io_word_address = 8'h02; mem_rstrb = 1'b1;
        @(negedge clk);
        idle_bus();
        v = io_rdata;
    endtask

    // Follows nfr contiguous frames cycle by cycle from offset t0, reading STATUS mid-frame.
    task automatic watch(input logic [7:0] b0, input logic [7:0] b1, input int nfr, input int t0);
        for (int t = t0; t < nfr * FRAME + 5; t++) begin
            bit rd;
            int f;
            logic e;
            rd = ((t % FRAME) == 50) && (t < nfr * FRAME);
            if (rd) begin
                io_sel = 1'b1; io_word_address = 8'h02; mem_rstrb = 1'b1;
            end
            @(negedge clk);
            if (rd) begin
                idle_bus();
                chk("status_mid_frame", io_rdata, st((nfr == 2 && t < FRAME) ? 1 : 0, 1'b1, 1'b0, 1'b0));
            end
            f = t / FRAME;
            e = (f >= nfr) ? 1'b1 : exp_tx((f == 0) ? b0 : b1, t % FRAME);
            chk("tx_waveform", {31'h0, tx}, {31'h0, e});
        end
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_rx_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && rx_q.size() > 0)
            chk({tag, "_rx_byte"}, {24'h0, rx_q.pop_front()}, {24'h0, exp_q.pop_front()});
        exp_q.delete();
        rx_q.delete();
    endtask

    // Line decoder: mid-bit sampling after the start edge; reset aborts a frame.
    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;
    always @(negedge clk) begin
        if (!reset) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == DIV / 2) begin
                chk("rx_start_bit", {31'h0, tx}, 32'h0);
            end else if (mon_cnt < 9 * DIV && ((mon_cnt - DIV / 2) % DIV) == 0) begin
                mon_byte[(mon_cnt - DIV / 2) / DIV - 1] = tx;
            end else if (mon_cnt == 9 * DIV + DIV / 2) begin
                chk("rx_stop_bit", {31'h0, tx}, 32'h1);
                rx_q.push_back(mon_byte);
                mon_active = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  b0, b1;

        // Reset
        repeat (3) @(negedge clk);
        chk("reset_tx", {31'h0, tx}, 32'h1);
        chk("reset_rdata", io_rdata, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        reset = 1'b1;
        rd_status(v);
        chk("status_after_reset", v, 32'h0000_0002);

        // Ignored writes: unmapped address, TXDATA without byte-0 strobe, io_sel low
        wr(1'b1, 8'h03, 32'h41, 4'hF);
        wr(1'b1, 8'h01, 32'h42, 4'b1110);
        wr(1'b0, 8'h01, 32'h43, 4'hF);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("ignored_tx_idle", {31'h0, tx}, 32'h1);
        end
        rd_status(v);
        chk("status_after_ignored", v, 32'h0000_0002);
        check_rx("ignored");

        // Single byte: 0x55 then a random byte
        for (int n = 0; n < 2; n++) begin
            b0 = (n == 0) ? 8'h55 : 8'($urandom());
            wr_byte(b0);
            chk("single_tx_before_pop", {31'h0, tx}, 32'h1);
            exp_q.push_back(b0);
            watch(b0, b0, 1, 0);
            check_rx("single");
        end

        // Back-to-back: 0xA5/0x3C then a random pair, no idle gap between frames
        for (int n = 0; n < 2; n++) begin
            b0 = (n == 0) ? 8'hA5 : 8'($urandom());
            b1 = (n == 0) ? 8'h3C : 8'($urandom());
            wr_byte(b0);
            chk("b2b_tx_before_pop", {31'h0, tx}, 32'h1);
            wr_byte(b1);
            chk("b2b_tx_start", {31'h0, tx}, 32'h0);
            exp_q.push_back(b0);
            exp_q.push_back(b1);
            watch(b0, b1, 2, 1);
            check_rx("b2b");
        end

        // Overflow: shifter busy, 9 further writes into an 8-deep FIFO
        b0 = 8'($urandom());
        wr_byte(b0);
        exp_q.push_back(b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            b1 = 8'($urandom());
            wr_byte(b1);
            if (i < DEPTH) exp_q.push_back(b1);
        end
        rd_status(v);
        chk("status_overflow", v, st(DEPTH, 1'b1, 1'b1, 1'b0));
        wr(1'b1, 8'h02, 32'h0000_0008, 4'b1110);
        rd_status(v);
        chk("status_ovf_kept_no_strobe", v, st(DEPTH, 1'b1, 1'b1, 1'b0));
        wr(1'b1, 8'h02, 32'h0000_0008, 4'b0001);
        rd_status(v);
        chk("status_ovf_cleared", v, st(DEPTH, 1'b1, 1'b0, 1'b0));
        repeat (9 * FRAME + 20) @(negedge clk);
        check_rx("overflow");
        rd_status(v);
        chk("status_drained", v, 32'h0000_0002);

        // Reset at cycle 35 of a frame with a second byte queued
        wr_byte(8'($urandom()));
        wr_byte(8'($urandom()));
        repeat (34) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_tx", {31'h0, tx}, 32'h1);
        reset = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            chk("midreset_tx_quiet", {31'h0, tx}, 32'h1);
        end
        rd_status(v);
        chk("midreset_status", v, 32'h0000_0002);
        check_rx("midreset");

        // Interrupt: enable, then one frame
        wr(1'b1, 8'h02, 32'h0000_0100, 4'b0010);
        chk("irq_en_latency", {31'h0, irq}, 32'h0);
        @(negedge clk);
        chk("irq_idle_enabled", {31'h0, irq}, {31'h0, IRQ_ON});
        rd_status(v);
        chk("status_irq_en", v, st(0, 1'b0, 1'b0, IRQ_ON));
        b0 = 8'($urandom());
        wr_byte(b0);
        exp_q.push_back(b0);
        chk("irq_at_push", {31'h0, irq}, {31'h0, IRQ_ON});
        for (int t = 0; t < FRAME + 4; t++) begin
            @(negedge clk);
            chk("irq_frame", {31'h0, irq}, {31'h0, (t >= FRAME + 1) ? IRQ_ON : 1'b0});
            chk("irq_tx", {31'h0, tx}, {31'h0, (t < FRAME) ? exp_tx(b0, t) : 1'b1});
        end
        check_rx("irq");
        wr(1'b1, 8'h02, 32'h0000_0000, 4'b0010);
        repeat (2) @(negedge clk);
        chk("irq_disabled", {31'h0, irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
